// File: rtl/poli_apb_master.sv
// APB master front-end for POLI: takes one read/write command at a time on a
// valid/ready port, runs a SETUP/ACCESS transfer with a bounded PREADY wait,
// and returns read data plus a timeout error flag on a valid/ready port.
module poli_apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic              busy
);

    localparam int CNT_W_RAW    = $clog2(TIMEOUT + 1);
    localparam int CNT_W        = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int TIMEOUT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    // Transfer sequencer: command accept, APB phases, wait/timeout, response hold
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q   <= 1'b0;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (wait_cnt_q != CNT_MAX) begin
                        // Saturates so a disabled timeout never wraps the count
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/poli_apb_master.md
Name: poli_apb_master

Overview:
APB master stage that sits directly upstream of the POLI top level and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA inputs. It consumes PRDATA/PREADY from POLI.
- Accepts single read/write commands on a valid/ready command port.
- Sequences each command through a standards-compliant APB SETUP/ACCESS transfer, honouring PREADY wait states with a bounded timeout.
- Returns read data and an error flag on a valid/ready response port.
- One transaction is outstanding at a time.

Parameters:
ADDR_W, 32, width of PADDR and cmd_addr (matches WORD_SIZE)
DATA_W, 32, width of PWDATA/PRDATA and command/response data (matches WORD_SIZE)
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
busy  out  1  state != IDLE

Behaviour:
- Reset state (asynchronous, nRST low):
  - State = IDLE; wait counter = 0.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0.
  - cmd_ready = 1 and busy = 0 once in IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch write/addr/wdata into PWRITE/PADDR/PWDATA, set PSEL = 1, go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0.
  - Set PENABLE = 1, clear wait counter, go to ACCESS.
- ACCESS:
  - PSEL = PENABLE = 1; PADDR/PWRITE/PWDATA are held stable.
  - If PREADY = 1: capture PRDATA into rsp_rdata (write: rsp_rdata = 0), rsp_err = 0, drop PSEL/PENABLE, set rsp_valid, go to RESP.
  - Else if TIMEOUT != 0 and the counter equals TIMEOUT-1: rsp_err = 1, rsp_rdata = 0, drop PSEL/PENABLE, set rsp_valid, go to RESP. The abort occurs on the TIMEOUT-th consecutive PREADY-low ACCESS cycle.
  - Else: counter += 1 and stay.
  - Counter width is $clog2(TIMEOUT+1), minimum 1 bit, and it never wraps.
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_err are held stable.
  - On rsp_ready: clear rsp_valid and rsp_err, go to IDLE.
  - rsp_rdata holds its value until the next capture.
- Command handshake:
  - cmd_ready = 0 in SETUP, ACCESS and RESP.
  - cmd_valid in those states is ignored, not queued.
  - A command presented at the same edge rsp_ready completes RESP is not accepted; it is accepted on the following IDLE cycle.
- Latency: command accepted at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> rsp_valid visible cycle 3 with zero wait states. Minimum issue interval is 4 cycles per transaction.
- After a transfer, PADDR/PWDATA/PWRITE keep their last values; only PSEL/PENABLE return to 0.
- Reset mid-operation: all outputs return to reset values immediately and the in-flight transaction and response are discarded. PSEL drops asynchronously.
- PRDATA is sampled only in ACCESS with PREADY = 1; PRDATA is ignored otherwise.

Test Plan:
- Write cmd addr=0x0000_0004 wdata=0xDEADBEEF, PREADY tied 1 -> PSEL rises cycle 1, PENABLE cycle 2 with PADDR=0x4, PWDATA=0xDEADBEEF, PWRITE=1; rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read cmd addr=0x0000_0008, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> PENABLE high 4 cycles, PADDR stable throughout; rsp_rdata=0x1234_5678, rsp_err=0.
- Read with PREADY held 0, TIMEOUT=16 -> PSEL/PENABLE drop after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; the next command completes normally.
- rsp_ready low 5 cycles after rsp_valid with cmd_valid held 1 -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; the command is accepted on the cycle after rsp_ready handshake.
- nRST asserted during ACCESS of a write -> PSEL/PENABLE/rsp_valid go 0 asynchronously, busy=0; no response is produced after release, and cmd_ready=1 on the first cycle after reset.
- Back-to-back: 3 commands with cmd_valid continuously high, PREADY=1, rsp_ready=1 -> exactly 3 APB transfers, one every 4 cycles, in order, with matching responses.
